data_array_access_ctrl: RTL and testbench

Front-end controller for the single-port 512x128 data array with 16 byte lanes. It arbitrates independent write and read request channels onto the one RW port and drives en, wmode, addr, wdata and the per-byte wmask. It captures read data one cycle after issue into a 2-entry response buffer with valid/ready back-pressure. It sits directly upstream of the data array wrapper and consumes its per-lane read outputs.

---
 rtl/data_array_access_ctrl_pkg.sv | 13 +
 rtl/data_array_access_ctrl_if.sv | 29 ++
 rtl/data_array_rsp_buf.sv | 37 +++
 rtl/data_array_access_ctrl.sv | 44 ++++
 tb/tb_data_array_access_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_array_access_ctrl_pkg.sv
// data_array_access_ctrl_pkg: shared widths and row types for the data array controller
package data_array_access_ctrl_pkg;
  localparam int ADDR_W = 9;
  localparam int LANES = 16;
  localparam int LANE_W = 8;
  localparam int ROW_W = LANES * LANE_W;
  localparam int STARVE_MAX = 4;
  localparam int RSP_DEPTH = 2;
  typedef logic [LANES-1:0][LANE_W-1:0] row_t;
  typedef logic [ROW_W-1:0] row_bits_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LANES-1:0] mask_t;
endpackage

// File: rtl/data_array_access_ctrl_if.sv
// data_array_access_ctrl_if: request, response and array-side signals of the data array controller
interface data_array_access_ctrl_if;
  import data_array_access_ctrl_pkg::*;
  logic wr_valid;
  logic wr_ready;
  addr_t wr_addr;
  row_t wr_data;
  mask_t wr_mask;
  logic rd_valid;
  logic rd_ready;
  addr_t rd_addr;
  logic rsp_valid;
  logic rsp_ready;
  row_t rsp_data;
  logic sram_en;
  logic sram_wmode;
  addr_t sram_addr;
  row_t sram_wdata;
  mask_t sram_wmask;
  row_t sram_rdata;
  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready, sram_rdata,
    input wr_ready, rd_ready, rsp_valid, rsp_data, sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask
  );
  modport slave (
    input wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready, sram_rdata,
    output wr_ready, rd_ready, rsp_valid, rsp_data, sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask
  );
endinterface

// File: rtl/data_array_rsp_buf.sv
// data_array_rsp_buf: two-entry response FIFO with capture/pop and occupancy output
module data_array_rsp_buf
  import data_array_access_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       capture,
  input  row_t       cdata,
  input  logic       pop,
  output logic [1:0] occ,
  output logic       rsp_valid,
  output row_t       rsp_data
);
  row_t mem [RSP_DEPTH];
  logic head;
  logic tail;
  logic take;
  assign rsp_valid = occ != 2'd0;
  assign rsp_data = mem[head];
  assign take = pop && rsp_valid;
  always_ff @(posedge clock) begin
    if (reset) begin
      mem <= '{default: '0};
      head <= 1'b0;
      tail <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (capture) begin
        mem[tail] <= cdata;
        tail <= ~tail;
      end
      if (take) head <= ~head;
      occ <= occ + {1'b0, capture} - {1'b0, take};
      assert (!capture || take || occ != 2'd2);
    end
  end
endmodule

// File: rtl/data_array_access_ctrl.sv
// data_array_access_ctrl: arbitrates write/read requests onto the single-port data array and buffers read responses
module data_array_access_ctrl
  import data_array_access_ctrl_pkg::*;
(
  input logic clock,
  input logic reset,
  data_array_access_ctrl_if.slave bus
);
  logic [2:0] starve_cnt;
  logic [1:0] occ;
  logic inflight;
  logic rd_ok;
  logic starve_force;
  logic wr_gnt;
  logic rd_gnt;
  assign rd_ok = (occ + {1'b0, inflight}) < 2'd2;
  assign starve_force = starve_cnt == 3'(STARVE_MAX);
  assign bus.wr_ready = !reset && !(starve_force && bus.rd_valid && rd_ok);
  assign wr_gnt = bus.wr_valid && bus.wr_ready;
  assign bus.rd_ready = !reset && rd_ok && !wr_gnt;
  assign rd_gnt = bus.rd_valid && bus.rd_ready;
  always_comb begin
    bus.sram_en = wr_gnt || rd_gnt;
    bus.sram_wmode = wr_gnt;
    bus.sram_addr = wr_gnt ? bus.wr_addr : rd_gnt ? bus.rd_addr : '0;
    bus.sram_wdata = wr_gnt ? bus.wr_data : '0;
    bus.sram_wmask = wr_gnt ? bus.wr_mask : '0;
  end
  always_ff @(posedge clock) begin
    inflight <= !reset && rd_gnt;
    starve_cnt <= (reset || rd_gnt || !bus.rd_valid) ? 3'd0 :
                  (wr_gnt && rd_ok) ? starve_cnt + 3'd1 : starve_cnt;
  end
  data_array_rsp_buf u_rsp_buf (
    .clock(clock),
    .reset(reset),
    .capture(inflight),
    .cdata(bus.sram_rdata),
    .pop(bus.rsp_ready),
    .occ(occ),
    .rsp_valid(bus.rsp_valid),
    .rsp_data(bus.rsp_data)
  );
endmodule

// File: tb/tb_data_array_access_ctrl.sv
// tb_data_array_access_ctrl: directed stimulus against a request-level model of the data array controller
module tb_data_array_access_ctrl;
  import data_array_access_ctrl_pkg::*;
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  data_array_access_ctrl_if bus();
  data_array_access_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  localparam row_t D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam row_t D1P = 128'h00112233_44556677_8899AABB_CCDDEE5A;
  localparam row_t DA = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
  localparam row_t DB = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
  localparam row_t DC = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam row_t DE = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
  localparam row_t DF = 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3;
  typedef struct {
    row_t d;
    int t;
  } exp_t;
  row_t arr [1 << ADDR_W];
  row_t ref_mem [1 << ADDR_W];
  exp_t q [$];
  int cyc = 0;
  int wcnt = 0;
  logic prev_rst = 1'b0;
  logic [15:0] gsh = '0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  function automatic row_t merge(input row_t old, input row_t d, input mask_t m);
    row_t r = old;
    for (int i = 0; i < LANES; i++) if (m[i]) r[i] = d[i];
    return r;
  endfunction
  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) arr[bus.sram_addr] <= merge(arr[bus.sram_addr], bus.sram_wdata, bus.sram_wmask);
      else bus.sram_rdata <= arr[bus.sram_addr];
    end
  end
  always @(negedge clock) begin
    logic ok, e_wrdy, e_rrdy, e_wg, e_rg, e_rv;
    if (reset) begin
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_ready", bus.rd_ready, 0);
      chk("rst_sram_en", bus.sram_en, 0);
      chk("rst_sram_wmode", bus.sram_wmode, 0);
      chk("rst_sram_wmask", bus.sram_wmask, 0);
      if (prev_rst) begin
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
      end
      q.delete();
      wcnt = 0;
    end else begin
      ok = q.size() < 2;
      e_wrdy = !(wcnt == STARVE_MAX && bus.rd_valid && ok);
      e_wg = bus.wr_valid && e_wrdy;
      e_rrdy = ok && !e_wg;
      e_rg = bus.rd_valid && e_rrdy;
      e_rv = q.size() > 0 && cyc >= q[0].t + 2;
      chk("wr_ready", bus.wr_ready, e_wrdy);
      chk("rd_ready", bus.rd_ready, e_rrdy);
      chk("sram_en", bus.sram_en, e_wg || e_rg);
      chk("sram_wmode", bus.sram_wmode, e_wg);
      chk("sram_wmask", bus.sram_wmask, e_wg ? bus.wr_mask : '0);
      chk("sram_addr", bus.sram_addr, e_wg ? bus.wr_addr : e_rg ? bus.rd_addr : '0);
      chk("sram_wdata", bus.sram_wdata, e_wg ? bus.wr_data : '0);
      chk("rsp_valid", bus.rsp_valid, e_rv);
      if (e_rv) chk("rsp_data", bus.rsp_data, q[0].d);
      if (e_rv && bus.rsp_ready) void'(q.pop_front());
      if (e_wg) ref_mem[bus.wr_addr] = merge(ref_mem[bus.wr_addr], bus.wr_data, bus.wr_mask);
      wcnt = (!bus.rd_valid || e_rg) ? 0 : (e_wg && ok) ? wcnt + 1 : wcnt;
      if (e_rg) q.push_back('{ref_mem[bus.rd_addr], cyc});
    end
    gsh = {gsh[14:0], bus.rd_valid && bus.rd_ready};
    prev_rst = reset;
    cyc++;
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic wr(input addr_t a, input row_t d, input mask_t m);
    bus.wr_valid = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_mask = m;
    tick();
    bus.wr_valid = 1'b0;
  endtask
  task automatic rd(input addr_t a);
    bus.rd_valid = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_valid = 1'b0;
  endtask
  task automatic get_rsp(input string nm, input row_t exp);
    int n = 0;
    @(negedge clock);
    while (!bus.rsp_valid && n < 8) begin
      n++;
      @(negedge clock);
    end
    chk({nm, "_valid"}, bus.rsp_valid, 1);
    chk(nm, bus.rsp_data, exp);
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int ng;
    reset = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_mask = '0;
    bus.rd_valid = 1'b0;
    bus.rd_addr = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr = 9'h1A5;
    bus.wr_data = D1;
    bus.wr_mask = 16'hFFFF;
    @(negedge clock);
    chk("w1_en", bus.sram_en, 1);
    chk("w1_wmode", bus.sram_wmode, 1);
    chk("w1_wmask", bus.sram_wmask, 16'hFFFF);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_addr = 9'h1A5;
    @(negedge clock);
    chk("r1_grant", bus.rd_ready, 1);
    tick();
    bus.rd_valid = 1'b0;
    @(negedge clock);
    chk("r1_lat1_valid", bus.rsp_valid, 0);
    tick();
    @(negedge clock);
    chk("r1_lat2_valid", bus.rsp_valid, 1);
    chk("r1_data", bus.rsp_data, D1);
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr = 9'h1A5;
    bus.wr_data = 128'h77777777_77777777_77777777_7777775A;
    bus.wr_mask = 16'h0001;
    @(negedge clock);
    chk("pw_wmask", bus.sram_wmask, 16'h0001);
    tick();
    bus.wr_valid = 1'b0;
    chk("pw_model_row", ref_mem[9'h1A5], D1P);
    rd(9'h1A5);
    get_rsp("pw_readback", D1P);
    wr(9'h020, DA, 16'hFFFF);
    wr(9'h021, DB, 16'hFFFF);
    wr(9'h022, DC, 16'hFFFF);
    bus.rsp_ready = 1'b0;
    bus.rd_valid = 1'b1;
    ng = 0;
    for (int i = 0; i < 6; i++) begin
      bus.rd_addr = 9'(32'h20 + ng);
      @(negedge clock);
      if (bus.rd_ready) ng++;
      tick();
    end
    chk("bp_grants", 128'(ng), 2);
    chk("bp_rd_ready", bus.rd_ready, 0);
    chk("bp_occ", dut.occ, 2);
    bus.rsp_ready = 1'b1;
    bus.rd_addr = 9'h022;
    get_rsp("bp_rsp0", DA);
    @(negedge clock);
    chk("bp_resume", bus.rd_ready, 1);
    chk("bp_rsp1_valid", bus.rsp_valid, 1);
    chk("bp_rsp1", bus.rsp_data, DB);
    tick();
    bus.rd_valid = 1'b0;
    get_rsp("bp_rsp2", DC);
    wr(9'h0F0, DE, 16'hFFFF);
    bus.wr_valid = 1'b1;
    bus.wr_mask = 16'hFFFF;
    bus.rd_valid = 1'b1;
    bus.rd_addr = 9'h0F0;
    for (int i = 0; i < 10; i++) begin
      bus.wr_addr = 9'(32'h100 + i);
      bus.wr_data = 128'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    chk("starve_pattern", gsh[9:0], 10'b0000100001);
    repeat (4) tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr = 9'h010;
    bus.wr_data = DF;
    bus.wr_mask = 16'hFFFF;
    bus.rd_valid = 1'b1;
    bus.rd_addr = 9'h010;
    @(negedge clock);
    chk("same_wr_first", bus.wr_ready, 1);
    chk("same_rd_wait", bus.rd_ready, 0);
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clock);
    chk("same_rd_next", bus.rd_ready, 1);
    tick();
    bus.rd_valid = 1'b0;
    get_rsp("same_data", DF);
    rd(9'h1A5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_rsp_data", bus.rsp_data, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rst_drop", bus.rsp_valid, 0);
    end
    tick();
    rd(9'h010);
    get_rsp("post_rst_read", DF);
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
